// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and time-field limits for the alarm controller.
package alarm_pkg;
    localparam int TIME_W = 6;
    localparam logic [TIME_W-1:0] MAX_SEC = 6'd59;
    localparam logic [TIME_W-1:0] MAX_MIN = 6'd59;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;
endpackage

// File: rtl/sec_tick_detect.sv
// sec_tick_detect: flags any cycle where the seconds value differs from the previous cycle.
module sec_tick_detect
    import alarm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] sec_i,
    output logic              tick_o
);
    logic [TIME_W-1:0] sec_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sec_q <= '0;
        else        sec_q <= sec_i;
    end
    assign tick_o = sec_i != sec_q;
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: compares digital_clock time against a stored alarm and runs the
// arm / ring / snooze FSM, with ring timeout and snooze length counted in clock seconds.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 30,
    parameter int SNOOZE_SECS = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] sec,
    input  logic [TIME_W-1:0] min,
    input  logic              set_en,
    input  logic [TIME_W-1:0] set_min,
    input  logic [TIME_W-1:0] set_sec,
    input  logic              arm,
    input  logic              disarm,
    input  logic              snooze,
    input  logic              stop,
    output logic              ring,
    output logic [1:0]        state,
    output logic [TIME_W-1:0] alarm_min,
    output logic [TIME_W-1:0] alarm_sec,
    output logic              set_err
);
    localparam int RC_W = $clog2(RING_SECS) + 1;
    localparam int SC_W = $clog2(SNOOZE_SECS) + 1;
    localparam logic [RC_W-1:0] RING_LD = RC_W'(RING_SECS);
    localparam logic [SC_W-1:0] SNZ_LD  = SC_W'(SNOOZE_SECS);

    state_t            state_q, state_d;
    logic [RC_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic [SC_W-1:0]   snz_cnt_q, snz_cnt_d;
    logic [TIME_W-1:0] alarm_min_q, alarm_min_d, alarm_sec_q, alarm_sec_d;
    logic              ring_q, set_err_q, set_err_d;
    logic              tick, match, stop_act, snz_act, set_act, set_ok;

    sec_tick_detect u_tick (.clk(clk), .rst_n(rst_n), .sec_i(sec), .tick_o(tick));

    assign match    = tick && min == alarm_min_q && sec == alarm_sec_q;
    // A command only counts as present when it can act in the current state
    assign stop_act = stop && (state_q == RINGING || state_q == SNOOZE);
    assign snz_act  = snooze && state_q == RINGING;
    assign set_act  = set_en && !disarm && !stop_act && !snz_act;
    assign set_ok   = (state_q == IDLE || state_q == ARMED) && set_min <= MAX_MIN && set_sec <= MAX_SEC;

    always_comb begin
        state_d     = state_q;
        ring_cnt_d  = ring_cnt_q;
        snz_cnt_d   = snz_cnt_q;
        alarm_min_d = set_act && set_ok ? set_min : alarm_min_q;
        alarm_sec_d = set_act && set_ok ? set_sec : alarm_sec_q;
        set_err_d   = set_act && !set_ok;
        if (disarm) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
        end else if (stop_act) begin
            state_d = ARMED;
        end else if (snz_act) begin
            state_d   = SNOOZE;
            snz_cnt_d = SNZ_LD;
        end else if (arm && !set_en && state_q == IDLE) begin
            state_d = ARMED;
        end else if (state_q == ARMED && match && !set_en) begin
            state_d    = RINGING;
            ring_cnt_d = RING_LD;
        end else if (state_q == RINGING && tick) begin
            ring_cnt_d = ring_cnt_q - 1'b1;
            state_d    = ring_cnt_q == RC_W'(1) ? ARMED : RINGING;
        end else if (state_q == SNOOZE && tick) begin
            snz_cnt_d  = snz_cnt_q - 1'b1;
            state_d    = snz_cnt_q == SC_W'(1) ? RINGING : SNOOZE;
            ring_cnt_d = snz_cnt_q == SC_W'(1) ? RING_LD : ring_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ring_cnt_q  <= '0;
            snz_cnt_q   <= '0;
            alarm_min_q <= '0;
            alarm_sec_q <= '0;
            ring_q      <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_cnt_q   <= snz_cnt_d;
            alarm_min_q <= alarm_min_d;
            alarm_sec_q <= alarm_sec_d;
            ring_q      <= state_d == RINGING;
            set_err_q   <= set_err_d;
        end
    end

    assign ring      = ring_q;
    assign state     = state_q;
    assign alarm_min = alarm_min_q;
    assign alarm_sec = alarm_sec_q;
    assign set_err   = set_err_q;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: scoreboard bench; a second-level alarm model predicts the outputs
// after every clock edge and a monitor compares them against the DUT.
module tb_alarm_controller;
    localparam int RING_SECS   = 4;
    localparam int SNOOZE_SECS = 3;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [5:0] sec = '0, min = '0, set_min = '0, set_sec = '0;
    logic       set_en = 0, arm = 0, disarm = 0, snooze = 0, stop = 0;
    logic       ring, set_err;
    logic [1:0] state;
    logic [5:0] alarm_min, alarm_sec;

    alarm_controller #(.RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)) dut (
        .clk(clk), .rst_n(rst_n), .sec(sec), .min(min), .set_en(set_en),
        .set_min(set_min), .set_sec(set_sec), .arm(arm), .disarm(disarm),
        .snooze(snooze), .stop(stop), .ring(ring), .state(state),
        .alarm_min(alarm_min), .alarm_sec(alarm_sec), .set_err(set_err)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp, mon_got;

    // reference model state: wall-clock time plus seconds left in ring/snooze
    int t_min = 0, t_sec = 0, prev_sec = 0;
    int mode = M_IDLE, a_min = 0, a_sec = 0, ring_left = 0, snz_left = 0;

    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {ring, state, alarm_min, alarm_sec, set_err};
            checks++;
            if (mon_got === mon_exp) passes++;
            else $display("FAIL scoreboard t=%0t got ring=%b st=%0d alarm=%0d:%0d err=%b, need ring=%b st=%0d alarm=%0d:%0d err=%b",
                $time, mon_got[15], mon_got[14:13], mon_got[12:7], mon_got[6:1], mon_got[0],
                mon_exp[15], mon_exp[14:13], mon_exp[12:7], mon_exp[6:1], mon_exp[0]);
        end
    end

    task automatic model_and_push();
        bit tick, match, err;
        int win;
        tick  = sec != prev_sec;
        match = tick && min == a_min && sec == a_sec;
        err   = 0;
        // pick the highest-priority command that means something in the current mode
        if (disarm) win = 1;
        else if (stop && (mode == M_RING || mode == M_SNZ)) win = 2;
        else if (snooze && mode == M_RING) win = 3;
        else if (set_en) win = 4;
        else if (arm && mode == M_IDLE) win = 5;
        else win = 0;
        case (win)
            1: begin mode = M_IDLE; ring_left = 0; snz_left = 0; end
            2: mode = M_ARMED;
            3: begin mode = M_SNZ; snz_left = SNOOZE_SECS; end
            5: mode = M_ARMED;
            default: ;
        endcase
        if (win == 4) begin
            if ((mode == M_IDLE || mode == M_ARMED) && set_min < 60 && set_sec < 60) begin
                a_min = set_min; a_sec = set_sec;
            end else err = 1;
        end
        // elapsed seconds still count when no state-changing command acted
        if (win == 0 || win == 4) begin
            if (mode == M_ARMED && match && win == 0) begin
                mode = M_RING; ring_left = RING_SECS;
            end else if (mode == M_RING && tick) begin
                ring_left--;
                if (ring_left == 0) mode = M_ARMED;
            end else if (mode == M_SNZ && tick) begin
                snz_left--;
                if (snz_left == 0) begin mode = M_RING; ring_left = RING_SECS; end
            end
        end
        prev_sec = sec;
        exp_q.push_back({mode == M_RING, 2'(mode), 6'(a_min), 6'(a_sec), err});
    endtask

    task automatic step(input bit adv, input bit de, st, sn, se, ar, input int sm, ss);
        @(negedge clk);
        if (adv) begin
            t_sec++;
            if (t_sec == 60) begin t_sec = 0; t_min = (t_min + 1) % 60; end
        end
        min = 6'(t_min); sec = 6'(t_sec);
        disarm = de; stop = st; snooze = sn; set_en = se; arm = ar;
        set_min = 6'(sm); set_sec = 6'(ss);
        model_and_push();
    endtask

    task automatic run(input int n, input bit adv);
        for (int i = 0; i < n; i++) step(adv, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ring, state, alarm_min, alarm_sec, set_err} === 16'd0) passes++;
        else $display("FAIL async_reset got ring=%b st=%0d alarm=%0d:%0d err=%b, need all zero",
            ring, state, alarm_min, alarm_sec, set_err);
        mode = M_IDLE; a_min = 0; a_sec = 0; ring_left = 0; snz_left = 0; prev_sec = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        do_reset();
        // ring at 00:05, timeout after RING_SECS ticks
        t_min = 0; t_sec = 0;
        step(0, 0, 0, 0, 1, 0, 0, 5);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        run(12, 1);
        // snooze then stop during re-ring
        t_min = 0; t_sec = 0;
        run(6, 1);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        run(5, 1);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        // rejected sets, then a set while ringing
        step(1, 0, 0, 0, 1, 0, 60, 10);
        step(1, 0, 0, 0, 1, 0, 1, 63);
        t_min = 0; t_sec = 0;
        run(6, 1);
        step(1, 0, 0, 0, 1, 0, 2, 2);
        run(6, 1);
        // alarm 00:00 across the hour wrap, then disarm together with stop
        step(1, 0, 0, 0, 1, 0, 0, 0);
        t_min = 59; t_sec = 56;
        run(4, 1);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        // hold seconds while ringing
        step(0, 0, 0, 0, 0, 1, 0, 0);
        t_min = 59; t_sec = 58;
        run(2, 1);
        run(10, 0);
        run(6, 1);
        // set_en on the matching tick: new time stored, no ring
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, t_min, (t_sec + 1) % 60);
        step(1, 0, 0, 0, 1, 0, 30, 30);
        run(4, 1);
        // reset mid-ring and mid-snooze, then arm at a standing 00:00
        step(0, 0, 0, 0, 1, 0, t_min, (t_sec + 2) % 60);
        run(3, 1);
        do_reset();
        step(0, 0, 0, 0, 1, 0, t_min, (t_sec + 2) % 60);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        run(3, 1);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        run(1, 1);
        do_reset();
        t_min = 0; t_sec = 0;
        step(0, 0, 0, 0, 0, 1, 0, 0);
        run(5, 0);
        t_min = 59; t_sec = 57;
        run(6, 1);
        // randomized traffic with alarms placed near the current time
        for (int i = 0; i < 2000; i++) begin
            bit de, st, sn, se, ar, adv;
            int sm, ss;
            r = $urandom_range(0, 99);
            de = r < 2; st = r >= 2 && r < 6; sn = r >= 6 && r < 10;
            se = r >= 10 && r < 15; ar = r >= 15 && r < 20;
            if (r >= 97) begin
                de = 1'($urandom); st = 1'($urandom); sn = 1'($urandom);
                se = 1'($urandom); ar = 1'($urandom);
            end
            sm = t_min; ss = (t_sec + $urandom_range(1, 8)) % 60;
            if ($urandom_range(0, 3) == 0) begin
                sm = $urandom_range(0, 63); ss = $urandom_range(0, 63);
            end
            adv = $urandom_range(0, 99) < 85;
            if ($urandom_range(0, 99) == 0) begin
                t_min = $urandom_range(0, 59); t_sec = $urandom_range(0, 59);
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            step(adv, de, st, sn, se, ar, sm, ss);
        end
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain got %0d pending, need 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
